// File: rtl/dma_copy_ctrl_if.sv
// DMA engine handshake bundle between the copy controller and the DMA engine.
// Latency: none, wires only.
// Backpressure: dma_empty / dma_full are carried to the controller.
interface dma_copy_ctrl_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64
) ();
    // read side
    logic                  dma_rd_go;
    logic                  dma_rd_en;
    logic [ADDR_WIDTH-1:0] dma_rd_addr;
    logic [ADDR_WIDTH:0]   dma_rd_size;
    logic [DATA_WIDTH-1:0] dma_rd_data;
    logic                  dma_empty;
    logic                  dma_rd_done;
    // write side
    logic                  dma_wr_go;
    logic                  dma_wr_en;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [ADDR_WIDTH:0]   dma_wr_size;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic                  dma_full;
    logic                  dma_wr_done;

    // controller side
    modport master (
        output dma_rd_go, dma_rd_en, dma_rd_addr, dma_rd_size,
        input  dma_rd_data, dma_empty, dma_rd_done,
        output dma_wr_go, dma_wr_en, dma_wr_addr, dma_wr_size, dma_wr_data,
        input  dma_full, dma_wr_done
    );

    // DMA engine side
    modport slave (
        input  dma_rd_go, dma_rd_en, dma_rd_addr, dma_rd_size,
        output dma_rd_data, dma_empty, dma_rd_done,
        input  dma_wr_go, dma_wr_en, dma_wr_addr, dma_wr_size, dma_wr_data,
        output dma_full, dma_wr_done
    );
endinterface

// File: rtl/dma_copy_ctrl.sv
// Cache-line copy controller: streams DMA read data straight into DMA write.
// Latency: read data reaches write data combinationally (zero added cycles).
// Backpressure: a beat moves only when !dma_empty && !dma_full; optional
// cycle counter built only with DMA_COPY_CTRL_CYCLES_EN defined.
module dma_copy_ctrl #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   size,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words,
    output logic [31:0]           cycles,
    dma_copy_ctrl_if.master       dma
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        WAIT_DONE,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   size_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic [ADDR_WIDTH:0]   words_nxt;
    logic                  busy_q;
    logic                  done_q;
    logic                  start_q;
    logic                  beat;
    logic                  accept;

    // A beat needs data available, room downstream, and lines still owed;
    // the words<size term keeps a late empty/full toggle from overshooting.
    assign beat      = (state == XFER) && !dma.dma_empty && !dma.dma_full
                       && (words_q < size_q);
    assign accept    = go && ((state == IDLE) || (state == DONE));
    assign words_nxt = words_q + 1'b1;

    assign dma.dma_rd_en   = beat;
    assign dma.dma_wr_en   = beat;
    assign dma.dma_wr_data = dma.dma_rd_data;
    assign dma.dma_rd_go   = start_q;
    assign dma.dma_wr_go   = start_q;
    assign dma.dma_rd_addr = src_q;
    assign dma.dma_wr_addr = dst_q;
    assign dma.dma_rd_size = size_q;
    assign dma.dma_wr_size = size_q;

    assign busy  = busy_q;
    assign done  = done_q;
    assign words = words_q;

    // Transfer sequencing; busy/done/start are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            size_q  <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        size_q  <= size;
                        words_q <= '0;
                        if (size == '0) begin
                            // nothing to move: finish without touching the DMA
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state   <= START;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            start_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state   <= XFER;
                end
                XFER: begin
                    if (beat) begin
                        words_q <= words_nxt;
                        if (words_nxt == size_q) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    // done flags are only looked at here, so leftovers from
                    // an earlier transfer cannot end this one early
                    if (dma.dma_rd_done && dma.dma_wr_done) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMA_COPY_CTRL_CYCLES_EN
    logic [31:0] cycles_q;

    // Cycles spent busy in the current transfer, saturating, frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else if (accept) begin
            cycles_q <= '0;
        end else if (((state == START) || (state == XFER) || (state == WAIT_DONE))
                     && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles = cycles_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign cycles        = 32'd0;
`endif

endmodule
